// File: rtl/transfer_receiver.sv
// transfer_receiver: recovers the scanner's serial link (clkIn/dataIn) into a show-ahead FIFO.
// Define TRANSFER_RECEIVER_PARITY_EN to expect a trailing even-parity bit on every frame.
module transfer_receiver #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clkIn,
  input  logic                     dataIn,
  output logic                     readyForTransfer,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     dataValid,
  input  logic                     dataRead,
  output logic [$clog2(DEPTH):0]   byteCount,
  output logic                     overflow,
  output logic                     timeoutError,
  output logic                     parityError,
  input  logic                     errorClear,
  output logic [1:0]               ps
);

`ifdef TRANSFER_RECEIVER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(FRAME + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    PUSH = 2'b10
  } state_t;

  logic             r_clk_s1, r_clk_s2, r_clk_s3;
  logic             r_dat_s1, r_dat_s2;
  state_t           r_state;
  logic [BW-1:0]    r_bit_cnt;
  logic [TW-1:0]    r_to_cnt;
  logic [FRAME-1:0] r_shift;
  logic             r_overflow;
  logic             r_timeout_err;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ready;

  logic             w_edge, w_full, w_empty, w_pop, w_push, w_frame_ok, w_ovf_drop;
  logic [CW-1:0]    w_count_next;

  // NOTE: every clocked register uses non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_s3 <= 1'b0;
      r_dat_s1 <= 1'b0;
      r_dat_s2 <= 1'b0;
    end else begin
      r_clk_s1 <= clkIn;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= dataIn;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_edge  = r_clk_s2 & ~r_clk_s3;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = dataRead & ~w_empty;

`ifdef TRANSFER_RECEIVER_PARITY_EN
  logic r_parity_err;
  assign w_frame_ok  = ~^r_shift;
  assign parityError = r_parity_err;
`else
  assign w_frame_ok  = 1'b1;
  assign parityError = 1'b0;
`endif

  assign w_push     = (r_state == PUSH) & w_frame_ok & (~w_full | w_pop);
  assign w_ovf_drop = (r_state == PUSH) & w_frame_ok & w_full & ~w_pop;

  // Clears are written first so a same-cycle set (later assignment) takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_to_cnt      <= '0;
      r_shift       <= '0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
`ifdef TRANSFER_RECEIVER_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end else begin
      if (errorClear) begin
        r_overflow    <= 1'b0;
        r_timeout_err <= 1'b0;
`ifdef TRANSFER_RECEIVER_PARITY_EN
        r_parity_err  <= 1'b0;
`endif
      end
      case (r_state)
        IDLE, PUSH: begin
          if (w_ovf_drop) r_overflow <= 1'b1;
`ifdef TRANSFER_RECEIVER_PARITY_EN
          if (r_state == PUSH && !w_frame_ok) r_parity_err <= 1'b1;
`endif
          r_bit_cnt <= '0;
          r_to_cnt  <= '0;
          r_state   <= IDLE;
          // An edge seen while pushing already belongs to the next word.
          if (w_edge) begin
            r_shift   <= {{(FRAME-1){1'b0}}, r_dat_s2};
            r_bit_cnt <= BW'(1);
            r_state   <= RECV;
          end
        end
        RECV: begin
          if (w_edge) begin
            r_shift   <= {r_shift[FRAME-2:0], r_dat_s2};
            r_bit_cnt <= r_bit_cnt + BW'(1);
            r_to_cnt  <= '0;
            if (r_bit_cnt == BW'(FRAME - 1)) r_state <= PUSH;
          end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
            r_bit_cnt     <= '0;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; dataOut is gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift[FRAME-1 -: WIDTH];
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_next = r_count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_ready <= (w_count_next != CW'(DEPTH));
    end
  end

  assign dataOut          = w_empty ? '0 : r_mem[r_rd_ptr];
  assign dataValid        = ~w_empty;
  assign byteCount        = r_count;
  assign readyForTransfer = r_ready;
  assign overflow         = r_overflow;
  assign timeoutError     = r_timeout_err;
  assign ps               = r_state;

endmodule

// File: tb/tb_transfer_receiver.sv
// Testbench for transfer_receiver: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized serial traffic.
module tb_transfer_receiver;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
`ifdef TRANSFER_RECEIVER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = WIDTH;
  localparam bit PAR   = 1'b0;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, clkIn, dataIn, dataRead, errorClear;
  logic             readyForTransfer, dataValid, overflow, timeoutError, parityError;
  logic [WIDTH-1:0] dataOut;
  logic [CW-1:0]    byteCount;
  logic [1:0]       ps;

  transfer_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .clkIn(clkIn), .dataIn(dataIn),
    .readyForTransfer(readyForTransfer), .dataOut(dataOut), .dataValid(dataValid),
    .dataRead(dataRead), .byteCount(byteCount), .overflow(overflow),
    .timeoutError(timeoutError), .parityError(parityError),
    .errorClear(errorClear), .ps(ps)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: link latency as a sample history, words as an int, FIFO as a queue.
  logic [3:0] hc = '0, hd = '0;
  int m_q[$];
  int m_nbits = 0, m_word = 0, m_to = 0;
  bit m_pend = 0, m_ovf = 0, m_tmo = 0, m_par = 0;

  always @(posedge clk) begin : model
    bit ev, b, pop, push, ok, set_o, set_t, set_p;
    int data, exp_do, exp_ps;
    if (rst) begin
      hc = '0; hd = '0; m_q.delete();
      m_nbits = 0; m_word = 0; m_to = 0;
      m_pend = 0; m_ovf = 0; m_tmo = 0; m_par = 0;
    end else begin
      hc = {hc[2:0], clkIn};
      hd = {hd[2:0], dataIn};
      ev = hc[2] && !hc[3];
      b  = hd[2];
      pop = dataRead && (m_q.size() > 0);
      push = 0; set_o = 0; set_t = 0; set_p = 0; data = 0;
      if (m_pend) begin
        data = m_word >> (FRAME - WIDTH);
        ok = !PAR || ($countones(m_word) % 2 == 0);
        if (!ok) set_p = 1;
        else if (m_q.size() == DEPTH && !pop) set_o = 1;
        else push = 1;
        m_pend = 0; m_nbits = 0; m_to = 0;
        if (ev) begin m_word = int'(b); m_nbits = 1; end
      end else if (m_nbits == 0) begin
        m_to = 0;
        if (ev) begin m_word = int'(b); m_nbits = 1; end
      end else if (ev) begin
        m_word = (m_word << 1) | int'(b);
        m_nbits++;
        m_to = 0;
        if (m_nbits == FRAME) m_pend = 1;
      end else begin
        m_to++;
        if (m_to == TIMEOUT) begin m_nbits = 0; m_to = 0; set_t = 1; end
      end
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(data);
      m_ovf = (m_ovf && !errorClear) || set_o;
      m_tmo = (m_tmo && !errorClear) || set_t;
      m_par = (m_par && !errorClear) || set_p;
    end
    #1;
    exp_do = (m_q.size() > 0) ? m_q[0] : 0;
    exp_ps = m_pend ? 2 : (m_nbits > 0 ? 1 : 0);
    check("dataValid", dataValid, m_q.size() > 0);
    check("dataOut", dataOut, exp_do);
    check("byteCount", byteCount, m_q.size());
    check("readyForTransfer", readyForTransfer, m_q.size() != DEPTH);
    check("overflow", overflow, m_ovf);
    check("timeoutError", timeoutError, m_tmo);
    check("parityError", parityError, m_par);
    check("ps", ps, exp_ps);
  end

  function automatic logic [FRAME-1:0] mk_frame(input logic [WIDTH-1:0] w, input bit bad);
    logic [WIDTH:0] t;
    t = {w, (^w) ^ bad};
    return t[WIDTH -: FRAME];
  endfunction

  // Sends the top nbits of f MSB first; optionally pops exactly in the resulting PUSH cycle.
  task automatic send_bits(input logic [FRAME-1:0] f, input int nbits, input int lo,
                           input int hi, input bit pop_at_push);
    for (int i = FRAME - 1; i >= FRAME - nbits; i--) begin
      @(negedge clk); clkIn = 1'b0; dataIn = f[i];
      repeat (lo - 1) @(negedge clk);
      @(negedge clk); clkIn = 1'b1;
      if (pop_at_push && i == FRAME - nbits) begin
        repeat (3) @(negedge clk);
        dataRead = 1'b1;
        @(negedge clk); dataRead = 1'b0;
      end else begin
        repeat (hi - 1) @(negedge clk);
      end
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    send_bits(mk_frame(w, 1'b0), FRAME, 8 - 4, 4, 1'b0);
    idle(5);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); clkIn = 1'b0; end
  endtask

  task automatic pop_expect(input logic [WIDTH-1:0] v);
    @(negedge clk);
    check("pop_head", dataOut, v);
    dataRead = 1'b1;
    @(negedge clk); dataRead = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk); errorClear = 1'b1;
    @(negedge clk); errorClear = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_ps", ps, 0);
    check("rst_dataOut", dataOut, 0);
    check("rst_dataValid", dataValid, 0);
    check("rst_byteCount", byteCount, 0);
    check("rst_ready", readyForTransfer, 1);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeoutError, 0);
    check("rst_parity", parityError, 0);
  endtask

  bit done = 0;
  int rd_pct = 0;

  initial begin
    rst = 1'b1; clkIn = 1'b0; dataIn = 1'b0; dataRead = 1'b0; errorClear = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    // Single word A5 at 8 clk/bit.
    send_word(8'hA5);
    check("a5_valid", dataValid, 1);
    check("a5_data", dataOut, 8'hA5);
    check("a5_count", byteCount, 1);
    pop_expect(8'hA5);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 4; i++) send_word(WIDTH'(i));
    check("full_count", byteCount, 4);
    check("full_ready", readyForTransfer, 0);
    send_word(8'h05);
    check("ovf_flag", overflow, 1);
    check("ovf_count", byteCount, 4);
    for (int i = 1; i <= 4; i++) pop_expect(WIDTH'(i));
    clear_flags();
    check("ovf_cleared", overflow, 0);

    // Fifth word's PUSH coincides with a pop.
    for (int i = 1; i <= 4; i++) send_word(WIDTH'(i));
    send_bits(mk_frame(8'h05, 1'b0), FRAME, 4, 4, 1'b1);
    idle(5);
    check("coinc_overflow", overflow, 0);
    check("coinc_count", byteCount, 4);
    for (int i = 2; i <= 5; i++) pop_expect(WIDTH'(i));

    // Partial word abandoned by timeout.
    send_word(8'h11);
    send_word(8'h22);
    send_bits(mk_frame(8'hE0, 1'b0), 3, 4, 4, 1'b0);
    idle(TIMEOUT + 8);
    check("tmo_flag", timeoutError, 1);
    check("tmo_ps", ps, 0);
    check("tmo_count", byteCount, 2);
    clear_flags();
    check("tmo_cleared", timeoutError, 0);
    send_word(8'h3C);
    check("tmo_next_count", byteCount, 3);
    pop_expect(8'h11);
    pop_expect(8'h22);
    pop_expect(8'h3C);

    // Reset mid-word with two words buffered.
    send_word(8'hAA);
    send_word(8'hBB);
    send_bits(mk_frame(8'hF8, 1'b0), 5, 4, 4, 1'b0);
    @(negedge clk); rst = 1'b1; clkIn = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_word(8'hFF);
    check("post_rst_count", byteCount, 1);
    check("post_rst_data", dataOut, 8'hFF);
    pop_expect(8'hFF);

`ifdef TRANSFER_RECEIVER_PARITY_EN
    send_bits(mk_frame(8'h03, 1'b0), FRAME, 4, 4, 1'b0);
    idle(5);
    check("par_good_count", byteCount, 1);
    check("par_good_flag", parityError, 0);
    send_bits(mk_frame(8'h03, 1'b1), FRAME, 4, 4, 1'b0);
    idle(5);
    check("par_bad_flag", parityError, 1);
    check("par_bad_count", byteCount, 1);
    check("par_bad_ovf", overflow, 0);
    clear_flags();
    check("par_cleared", parityError, 0);
    pop_expect(8'h03);
`endif

    // Randomized traffic: first phase mostly unread (overflows), then slow draining.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          int lo, hi;
          lo = $urandom_range(3, 6);
          hi = $urandom_range(3, 6);
          rd_pct = (n < 15) ? 0 : 4;
          if ($urandom_range(0, 7) == 0) begin
            send_bits(mk_frame(WIDTH'($urandom), 1'b0), $urandom_range(1, FRAME - 1), lo, hi, 1'b0);
            idle(TIMEOUT + $urandom_range(2, 10));
          end else begin
            send_bits(mk_frame(WIDTH'($urandom), PAR && ($urandom_range(0, 5) == 0)),
                      FRAME, lo, hi, 1'b0);
            idle($urandom_range(1, 6));
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          dataRead   = ($urandom_range(0, 99) < rd_pct);
          errorClear = ($urandom_range(0, 199) == 0);
        end
        dataRead   = 1'b0;
        errorClear = 1'b0;
      end
    join

    idle(6);
    repeat (DEPTH + 2) begin @(negedge clk); dataRead = 1'b1; end
    @(negedge clk); dataRead = 1'b0;
    check("drain_count", byteCount, 0);
    check("drain_ready", readyForTransfer, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/transfer_receiver.md
# transfer_receiver

Serial receiving end of the scanner transfer link. Recovers the scanner's bit clock (`clkOut`) and serial data (`dataOut`) in the local `clk` domain, assembles MSB-first words into a small show-ahead FIFO, and presents them to the local consumer through a valid/read handshake. Drives `readyForTransfer` back to the scanner's `readyForTransferIn` so the scanner only sends when buffer space exists.

## Interface
- WIDTH, 8, bits per word
- DEPTH, 4, FIFO entries (power of two, ≥2)
- TIMEOUT, 64, `clk` cycles without a `clkIn` rising edge before a partial word is abandoned

- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- clkIn  in  1  serial bit clock from scanner `clkOut`, asynchronous to `clk`
- dataIn  in  1  serial data from scanner `dataOut`, stable around `clkIn` rising edge
- readyForTransfer  out  1  to scanner `readyForTransferIn`; high when FIFO has ≥1 free entry
- dataOut  out  WIDTH  FIFO head word
- dataValid  out  1  FIFO non-empty
- dataRead  in  1  consumer pops head when `dataValid` high; ignored when empty
- byteCount  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky; word completed while FIFO full
- timeoutError  out  1  sticky; partial word abandoned
- parityError  out  1  sticky; parity mismatch (0 when parity compiled out)
- errorClear  in  1  synchronous clear of all sticky flags
- ps  out  2  debug: current state

## Operation
- `clkIn` and `dataIn` each pass through a 2-flop synchronizer; `clkIn` rising edge is detected by comparing the synchronized value with a third flop.
- States: IDLE=2'b00, RECV=2'b01, PUSH=2'b10.
- IDLE: bit counter 0, timeout counter 0. On detected edge: shift in the synchronized `dataIn`, counter=1, go to RECV.
- RECV: each edge shifts in a bit (MSB first) and resets the timeout counter; otherwise the timeout counter increments. When the counter reaches the frame length (WIDTH, or WIDTH+1 with parity), go to PUSH. When the timeout counter reaches TIMEOUT, discard the partial word, set `timeoutError`, go to IDLE.
- PUSH (one cycle): if FIFO not full, or `dataRead` pops in the same cycle, write the word. Otherwise drop the word and set `overflow`. Go to IDLE. An edge arriving during PUSH is treated as bit 1 of the next word.
- FIFO: pointer-based, wraps modulo DEPTH. A simultaneous push and pop leaves `byteCount` unchanged. A pop while empty has no effect.
- `errorClear` clears the sticky flags. If a flag-setting event occurs in the same cycle as `errorClear`, the set wins.
- Reset mid-word discards the partial word and all FIFO contents.

## Timing
- Reset values:
  - `ps`=IDLE
  - `dataOut`=0
  - `dataValid`=0
  - `byteCount`=0
  - `readyForTransfer`=1
  - all sticky flags 0
- `clkIn` high and low phases must each last ≥3 `clk` cycles. `dataIn` must be stable from 3 cycles before to 3 cycles after the `clkIn` rising edge.
- A `clkIn` rising edge is acted on 3 `clk` cycles after it occurs (2 synchronizer cycles + 1 edge-detect cycle).
- The last bit is captured in cycle N. PUSH occurs in N+1. `dataValid`, `dataOut`, and `byteCount` update in N+2.
- `readyForTransfer` is registered from the next-cycle occupancy. It falls in the same cycle that `byteCount` reaches DEPTH.
- A pop is reflected in `dataOut` and `byteCount` on the next cycle.

## Configuration
- `TRANSFER_RECEIVER_PARITY_EN` defined:
  - Each frame carries WIDTH data bits followed by one even-parity bit.
  - On mismatch in PUSH: drop the word, set `parityError`, do not write the FIFO, do not set `overflow`.
- Undefined:
  - The frame is WIDTH bits.
  - `parityError` is tied 0.

## Test plan
- Reset, then 8 serial bits 1010_0101 at 8 clk/bit → `dataValid`=1 and `dataOut`=8'hA5 two cycles after the 8th bit is captured; `byteCount`=1.
- Send 4 words 01,02,03,04 with no reads → `byteCount`=4, `readyForTransfer`=0. A 5th word 05 → dropped, `overflow`=1. Pop 4 times → reads 01..04 in order.
- FIFO full, 5th word's PUSH coincides with `dataRead` → 01 popped, 05 accepted, `byteCount` stays 4, `overflow`=0.
- Send 3 bits, then hold `clkIn` low for 64 cycles → `timeoutError`=1, `ps`=IDLE, FIFO unchanged. A following full word 8'h3C is received correctly.
- Assert `rst` after 5 bits with 2 words buffered → all outputs return to reset values immediately. A following word 8'hFF is received alone.
- With `TRANSFER_RECEIVER_PARITY_EN`: 8'h03 + parity 0 → accepted. 8'h03 + parity 1 → dropped, `parityError`=1. `errorClear` → flag cleared the next cycle.
